// File: rtl/pll_clkdiv_gen.sv
// pll_clkdiv_gen: NUM_CH runtime-programmable clock dividers with phase offsets and a shared lock flag
//   refclk    - single clock for all logic
//   rst       - synchronous active-high reset
//   cfg_valid - reconfiguration request; cfg_ready - request can be accepted (LOCKED only)
//   cfg_ch    - target channel; cfg_div - new divisor (<2 stored as 2); cfg_phase - phase offset
//   ch_en     - per-channel output enable (counters keep running while disabled)
//   outclk    - registered divided clock per channel
//   clk_ce    - registered one-cycle strobe on the last count of each period
//   locked    - all channels aligned and stable
module pll_clkdiv_gen #(
    parameter int NUM_CH      = 4,
    parameter int DIV_W       = 16,
    parameter int DEFAULT_DIV = 20,
    parameter int LOCK_CYCLES = 16,
    localparam int CH_W       = NUM_CH > 1 ? $clog2(NUM_CH) : 1,
    localparam int LK_W       = LOCK_CYCLES > 1 ? $clog2(LOCK_CYCLES) : 1
) (
    input  logic              refclk,
    input  logic              rst,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    input  logic [CH_W-1:0]   cfg_ch,
    input  logic [DIV_W-1:0]  cfg_div,
    input  logic [DIV_W-1:0]  cfg_phase,
    input  logic [NUM_CH-1:0] ch_en,
    output logic [NUM_CH-1:0] outclk,
    output logic [NUM_CH-1:0] clk_ce,
    output logic              locked
);
    typedef enum logic [1:0] {ALIGN, LOCKING, LOCKED} state_t;
    state_t            state;
    logic [LK_W-1:0]   lock_cnt;
    logic [DIV_W-1:0]  div   [NUM_CH];
    logic [DIV_W-1:0]  phase [NUM_CH];
    logic [DIV_W-1:0]  cnt   [NUM_CH];
    logic [DIV_W-1:0]  ph_mod [NUM_CH];
    logic [DIV_W-1:0]  cnt_n  [NUM_CH];
    logic              acc;
    logic              lock_n;

    assign acc    = cfg_valid && cfg_ready;
    assign lock_n = (state == LOCKING && lock_cnt == LK_W'(LOCK_CYCLES - 1)) || (state == LOCKED && !acc);

    // Phase is reduced with a single subtract; anything at or beyond 2*div falls back to 0.
    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            ph_mod[i] = phase[i] < div[i] ? phase[i] :
                        (phase[i] - div[i] < div[i] ? phase[i] - div[i] : '0);
            cnt_n[i]  = state == ALIGN ? ph_mod[i] :
                        (cnt[i] == div[i] - DIV_W'(1) ? '0 : cnt[i] + DIV_W'(1));
        end
    end

    // Outputs are registered from next-state values so they line up with cnt in the same cycle.
    always_ff @(posedge refclk) begin
        if (rst) begin
            state     <= ALIGN;
            lock_cnt  <= '0;
            locked    <= 1'b0;
            cfg_ready <= 1'b0;
            outclk    <= '0;
            clk_ce    <= '0;
            for (int i = 0; i < NUM_CH; i++) begin
                div[i]   <= DIV_W'(DEFAULT_DIV);
                phase[i] <= '0;
                cnt[i]   <= '0;
            end
        end else begin
            locked    <= lock_n;
            cfg_ready <= lock_n;
            lock_cnt  <= state == LOCKING ? lock_cnt + LK_W'(1) : '0;
            for (int i = 0; i < NUM_CH; i++) begin
                cnt[i]    <= cnt_n[i];
                outclk[i] <= lock_n && ch_en[i] && (cnt_n[i] < (div[i] >> 1));
                clk_ce[i] <= lock_n && ch_en[i] && (cnt_n[i] == div[i] - DIV_W'(1));
            end
            case (state)
                ALIGN:   state <= LOCKING;
                LOCKING: state <= lock_n ? LOCKED : LOCKING;
                default: begin
                    if (acc) begin
                        state <= ALIGN;
                        // Out-of-range channels match no index: handshake and relock only.
                        for (int i = 0; i < NUM_CH; i++) begin
                            if (cfg_ch == CH_W'(i)) begin
                                div[i]   <= cfg_div < DIV_W'(2) ? DIV_W'(2) : cfg_div;
                                phase[i] <= cfg_phase;
                            end
                        end
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_pll_clkdiv_gen.sv
// tb_pll_clkdiv_gen: scoreboard bench for pll_clkdiv_gen with a cycle-position reference model
module tb_pll_clkdiv_gen;
    localparam int N  = 4;
    localparam int DW = 16;
    localparam int LC = 16;
    localparam int DD = 20;

    logic          refclk = 1'b0;
    logic          rst = 1'b1;
    logic          cfg_valid = 1'b0;
    logic          cfg_ready;
    logic [1:0]    cfg_ch = '0;
    logic [DW-1:0] cfg_div = '0;
    logic [DW-1:0] cfg_phase = '0;
    logic [N-1:0]  ch_en = '0;
    logic [N-1:0]  outclk;
    logic [N-1:0]  clk_ce;
    logic          locked;

    logic          b_valid = 1'b0;
    logic          b_ready;
    logic [1:0]    b_ch = '0;
    logic [DW-1:0] b_div = '0;
    logic [DW-1:0] b_phase = '0;
    logic [2:0]    b_outclk;
    logic [2:0]    b_ce;
    logic          b_locked;

    pll_clkdiv_gen #(.NUM_CH(N), .DIV_W(DW), .DEFAULT_DIV(DD), .LOCK_CYCLES(LC)) u_dut (
        .refclk(refclk), .rst(rst), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
        .cfg_ch(cfg_ch), .cfg_div(cfg_div), .cfg_phase(cfg_phase), .ch_en(ch_en),
        .outclk(outclk), .clk_ce(clk_ce), .locked(locked)
    );

    // Three-channel instance so that channel index 3 is out of range.
    pll_clkdiv_gen #(.NUM_CH(3), .DIV_W(DW), .DEFAULT_DIV(6), .LOCK_CYCLES(4)) u_odd (
        .refclk(refclk), .rst(rst), .cfg_valid(b_valid), .cfg_ready(b_ready),
        .cfg_ch(b_ch), .cfg_div(b_div), .cfg_phase(b_phase), .ch_en(3'b111),
        .outclk(b_outclk), .clk_ce(b_ce), .locked(b_locked)
    );

    always #5 refclk = ~refclk;

    int checks = 0;
    int fails = 0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    int cyc = 0;
    logic rst_q = 1'b1, v_q = 1'b0;
    logic [1:0] ch_q = '0;
    logic [DW-1:0] div_q = '0, ph_q = '0;
    logic [N-1:0] en_q = '0;
    always @(posedge refclk) begin
        cyc   <= cyc + 1;
        rst_q <= rst;
        v_q   <= cfg_valid;
        ch_q  <= cfg_ch;
        div_q <= cfg_div;
        ph_q  <= cfg_phase;
        en_q  <= ch_en;
    end

    int m_div [N];
    int m_ph  [N];
    int t_align = 0;
    bit m_rdy = 1'b0;
    bit prev_rst = 1'b1;
    bit lk_prev = 1'b0;
    int lockq [$];

    // Expected state after edge k: channel position = (reduced phase + edges since ALIGN) mod div.
    always @(negedge refclk) begin
        int k, d, p, pm, c;
        bit el;
        if (cyc > 0) begin
            k = cyc;
            if (rst_q) begin
                for (int i = 0; i < N; i++) begin
                    m_div[i] = DD;
                    m_ph[i]  = 0;
                end
                t_align = k + 1;
                lockq.delete();
            end else begin
                if (prev_rst)
                    lockq.push_back(k + LC);
                if (v_q && m_rdy) begin
                    if (int'(ch_q) < N) begin
                        m_div[ch_q] = int'(div_q) < 2 ? 2 : int'(div_q);
                        m_ph[ch_q]  = int'(ph_q);
                    end
                    t_align = k + 1;
                    lockq.push_back(k + 1 + LC);
                end
            end
            prev_rst = rst_q;
            el = k >= t_align + LC;
            m_rdy = el;
            chk("locked", 32'(locked), 32'(el));
            chk("cfg_ready", 32'(cfg_ready), 32'(el));
            for (int i = 0; i < N; i++) begin
                d  = m_div[i];
                p  = m_ph[i];
                pm = p < d ? p : (p < 2 * d ? p - d : 0);
                c  = k >= t_align ? (pm + k - t_align) % d : 0;
                chk($sformatf("outclk%0d", i), 32'(outclk[i]), 32'(el && en_q[i] && c < d / 2));
                chk($sformatf("clk_ce%0d", i), 32'(clk_ce[i]), 32'(el && en_q[i] && c == d - 1));
            end
            if (locked && !lk_prev) begin
                if (lockq.size() == 0)
                    chk("lock_unexpected", 32'(1), 32'(0));
                else
                    chk("lock_rise_cycle", 32'(k), 32'(lockq.pop_front()));
            end
            lk_prev = locked;
        end
    end

    task automatic write(input logic [1:0] ch, input int d, input int p);
        bit ok = 1'b0;
        cfg_ch = ch;
        cfg_div = DW'(d);
        cfg_phase = DW'(p);
        cfg_valid = 1'b1;
        for (int i = 0; i < 100 && !ok; i++) begin
            @(negedge refclk);
            ok = cfg_ready;
            @(posedge refclk);
            #1;
        end
        if (!ok)
            chk("write_timeout", 32'(0), 32'(1));
        cfg_valid = 1'b0;
    endtask

    task automatic run(input int n);
        repeat (n) @(posedge refclk);
        #1;
    endtask

    initial begin
        int n, ce_cnt, hi_cnt;
        ch_en = 4'hF;
        repeat (3) @(posedge refclk);
        #1 rst = 1'b0;
        run(200);
        write(2'd1, 7, 3);
        run(80);
        write(2'd2, 0, 0);
        run(40);
        write(2'd2, 1, 0);
        run(40);
        write(2'd0, 20, 5);
        write(2'd3, 9, 12);
        run(40);
        write(2'd3, 5, 11);
        run(40);
        ch_en[0] = 1'b0;
        run(33);
        ch_en[0] = 1'b1;
        run(50);
        write(2'd1, 7, 3);
        run(5);
        rst = 1'b1;
        run(1);
        rst = 1'b0;
        run(60);

        for (int i = 0; i < 50 && !b_ready; i++) run(1);
        chk("oor_ready", 32'(b_ready), 32'(1));
        b_valid = 1'b1;
        b_ch = 2'd3;
        b_div = DW'(2);
        b_phase = DW'(1);
        run(1);
        b_valid = 1'b0;
        @(negedge refclk);
        chk("oor_lock_drop", 32'(b_locked), 32'(0));
        n = 1;
        for (int i = 0; i < 30 && !b_locked; i++) begin
            @(negedge refclk);
            if (!b_locked) n++;
        end
        chk("oor_relock", 32'(n), 32'(5));
        for (int c = 0; c < 3; c++) begin
            ce_cnt = 0;
            hi_cnt = 0;
            for (int i = 0; i < 12; i++) begin
                @(negedge refclk);
                ce_cnt += int'(b_ce[c]);
                hi_cnt += int'(b_outclk[c]);
            end
            chk($sformatf("oor_ce%0d", c), 32'(ce_cnt), 32'(2));
            chk($sformatf("oor_hi%0d", c), 32'(hi_cnt), 32'(6));
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end
endmodule
